// File: rtl/icache_pkg.sv
// icache_pkg: shared types for the direct-mapped instruction cache.
//   word_t          32-bit machine word
//   icache_state_t  cache controller states (IDLE, FETCH)
//   icachef_t       one cache frame: valid bit, tag, data word
// The optional statistics counters are selected with ICACHE_STATS_EN.
package icache_pkg;

  typedef logic [31:0] word_t;

  // Widest tag any legal NSETS can need (NSETS=2 leaves 29 tag bits).
  // Smaller caches store their tag zero-extended into this field, so the
  // package never needs to know NSETS.
  localparam int TAG_MAX_W = $bits(word_t) - 3;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } icache_state_t;

  typedef struct packed {
    logic                 valid;
    logic [TAG_MAX_W-1:0] tag;
    word_t                data;
  } icachef_t;

  // Drops the byte offset so memory always sees a word address.
  function automatic word_t word_align(input word_t addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/icache_if.sv
// icache_if: fetch-side and memory-side signals of the instruction cache.
//   imemREN/imemaddr  fetch request from the datapath
//   ihit/imemload     fetch response to the datapath
//   iREN/iaddr        single-word read request to the memory controller
//   iwait/iload       memory controller busy flag and read data
// Modports: slave is the cache's view, master is the view of whatever
// drives fetches and answers memory reads.
// The optional statistics counters are selected with ICACHE_STATS_EN.
interface icache_if;
  import icache_pkg::*;

  logic  imemREN;
  word_t imemaddr;
  logic  ihit;
  word_t imemload;
  logic  iREN;
  word_t iaddr;
  logic  iwait;
  word_t iload;

  modport slave (
    input  imemREN, imemaddr, iwait, iload,
    output ihit, imemload, iREN, iaddr
  );

  modport master (
    output imemREN, imemaddr, iwait, iload,
    input  ihit, imemload, iREN, iaddr
  );

endinterface

// File: rtl/icache_counter.sv
// icache_counter: 32-bit event counter that wraps to zero.
//   CLK    clock, counts on the rising edge
//   RST    synchronous active-high clear
//   inc    count this cycle
//   count  current value
// Only instantiated when ICACHE_STATS_EN is defined.
module icache_counter
  import icache_pkg::*;
(
  input  logic  CLK,
  input  logic  RST,
  input  logic  inc,
  output word_t count
);

  word_t count_q;
  word_t count_d;

  // Plain 32-bit add; overflow past all-ones naturally wraps to zero.
  always_comb begin
    count_d = count_q;
    if (inc) begin
      count_d = count_q + 32'd1;
    end
  end

  // Counter register, cleared by reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/icache.sv
// icache: direct-mapped, read-only instruction cache.
//   CLK, RST     clock and synchronous active-high reset
//   dcif         icache_if.slave: fetch request/response and memory read port
//   hit_count    cycles with a hit        (only with ICACHE_STATS_EN)
//   miss_count   IDLE->FETCH transitions  (only with ICACHE_STATS_EN)
// Hits answer combinationally from the frame array. A miss latches the
// word address and reads one word from memory, then refills that frame.
module icache
  import icache_pkg::*;
#(
  parameter int NSETS = 16
) (
  input  logic  CLK,
  input  logic  RST,
`ifdef ICACHE_STATS_EN
  output word_t hit_count,
  output word_t miss_count,
`endif
  icache_if.slave dcif
);

  localparam int IDX_W = $clog2(NSETS);
  localparam int TAG_W = 30 - IDX_W;

  icache_state_t state_q, state_d;
  word_t         miss_addr_q, miss_addr_d;
  icachef_t      frames_q [NSETS];
  icachef_t      frames_d [NSETS];

  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic [IDX_W-1:0] fill_idx;
  logic [TAG_W-1:0] fill_tag;
  logic             hit;

  assign req_idx  = dcif.imemaddr[IDX_W+1:2];
  assign req_tag  = dcif.imemaddr[31:IDX_W+2];
  assign fill_idx = miss_addr_q[IDX_W+1:2];
  assign fill_tag = miss_addr_q[31:IDX_W+2];

  // Hit lookup is purely combinational so fetch can advance in the same
  // cycle; nothing hits while a fill is outstanding.
  always_comb begin
    hit = 1'b0;
    if (state_q == IDLE && dcif.imemREN && frames_q[req_idx].valid &&
        frames_q[req_idx].tag == TAG_MAX_W'(req_tag)) begin
      hit = 1'b1;
    end
  end

  assign dcif.ihit     = hit;
  assign dcif.imemload = hit ? frames_q[req_idx].data : '0;

  // Memory request comes straight from registers so it cannot glitch.
  assign dcif.iREN  = (state_q == FETCH);
  assign dcif.iaddr = miss_addr_q;

  // Next-state logic. Once in FETCH the fill runs to completion using the
  // latched address, whatever the fetch port does in the meantime.
  always_comb begin
    state_d     = state_q;
    miss_addr_d = miss_addr_q;
    frames_d    = frames_q;
    case (state_q)
      IDLE: begin
        if (dcif.imemREN && !hit) begin
          miss_addr_d = word_align(dcif.imemaddr);
          state_d     = FETCH;
        end
      end
      FETCH: begin
        if (!dcif.iwait) begin
          frames_d[fill_idx] = '{valid: 1'b1,
                                 tag:   TAG_MAX_W'(fill_tag),
                                 data:  dcif.iload};
          state_d = IDLE;
        end
      end
    endcase
  end

  // State, miss address and frames. Reset takes priority over a completing
  // fill, so an in-flight word is simply dropped.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      miss_addr_q <= '0;
      for (int i = 0; i < NSETS; i++) begin
        frames_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      miss_addr_q <= miss_addr_d;
      frames_q    <= frames_d;
    end
  end

`ifdef ICACHE_STATS_EN
  logic miss_inc;

  // A miss is counted once, on the cycle the controller leaves IDLE.
  assign miss_inc = (state_q == IDLE) && (state_d == FETCH);

  icache_counter u_hit_counter (
    .CLK   (CLK),
    .RST   (RST),
    .inc   (hit),
    .count (hit_count)
  );

  icache_counter u_miss_counter (
    .CLK   (CLK),
    .RST   (RST),
    .inc   (miss_inc),
    .count (miss_count)
  );
`endif

endmodule

// File: tb/tb_icache.sv
// tb_icache: self-checking bench for icache (NSETS=16).
// A behavioural cache model is checked against the DUT on every falling
// edge; directed steps additionally pin hand-computed values.
// Statistics checks are compiled when ICACHE_STATS_EN is defined.
module tb_icache;
  import icache_pkg::*;

  localparam int NSETS = 16;
  localparam int IDX_W = $clog2(NSETS);

  typedef enum {L_NONE, L_IHIT, L_LOAD, L_IREN, L_IADDR, L_HITS, L_MISSES} lit_sel_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  icache_if bus();

`ifdef ICACHE_STATS_EN
  word_t hit_count;
  word_t miss_count;
`endif

  icache #(.NSETS(NSETS)) dut (
    .CLK        (clk),
    .RST        (rst),
`ifdef ICACHE_STATS_EN
    .hit_count  (hit_count),
    .miss_count (miss_count),
`endif
    .dcif       (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // One hand-computed expectation per cycle, set by the stimulus.
  lit_sel_t lit_sel  = L_NONE;
  word_t    lit_exp  = '0;
  string    lit_name = "";
  word_t    hit_bias = '0;

  // Behavioural model: contents per index plus an outstanding fill.
  bit    m_ready = 1'b0;
  bit    m_valid [NSETS];
  word_t m_tag   [NSETS];
  word_t m_data  [NSETS];
  bit    m_pend  = 1'b0;
  word_t m_addr  = '0;
  word_t m_hits  = '0;
  word_t m_misses = '0;

  task automatic checkOutput(input string name, input word_t act, input word_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare on the falling edge, then advance the model to the state the
  // coming rising edge should produce.
  always @(negedge clk) begin : compare
    int    idx;
    int    fidx;
    word_t tag;
    bit    exp_hit;
    idx     = int'(bus.imemaddr[31:2]) % NSETS;
    tag     = bus.imemaddr >> (IDX_W + 2);
    exp_hit = m_ready && !m_pend && (bus.imemREN === 1'b1) &&
              m_valid[idx] && (m_tag[idx] == tag);
    if (m_ready) begin
      checkOutput("model_ihit", 32'(bus.ihit), 32'(exp_hit));
      checkOutput("model_imemload", bus.imemload, exp_hit ? m_data[idx] : 32'h0);
      checkOutput("model_iREN", 32'(bus.iREN), 32'(m_pend));
      if (m_pend) begin
        checkOutput("model_iaddr", bus.iaddr, m_addr);
      end
`ifdef ICACHE_STATS_EN
      checkOutput("model_hit_count", hit_count, m_hits + hit_bias);
      checkOutput("model_miss_count", miss_count, m_misses);
`endif
    end
    case (lit_sel)
      L_IHIT:   checkOutput(lit_name, 32'(bus.ihit), lit_exp);
      L_LOAD:   checkOutput(lit_name, bus.imemload, lit_exp);
      L_IREN:   checkOutput(lit_name, 32'(bus.iREN), lit_exp);
      L_IADDR:  checkOutput(lit_name, bus.iaddr, lit_exp);
`ifdef ICACHE_STATS_EN
      L_HITS:   checkOutput(lit_name, hit_count, lit_exp);
      L_MISSES: checkOutput(lit_name, miss_count, lit_exp);
`endif
      default: ;
    endcase
    if (rst) begin
      for (int i = 0; i < NSETS; i++) m_valid[i] = 1'b0;
      m_pend   = 1'b0;
      m_hits   = '0;
      m_misses = '0;
      m_ready  = 1'b1;
    end else if (m_ready) begin
      if (exp_hit) m_hits = m_hits + 32'd1;
      if (m_pend) begin
        if (!bus.iwait) begin
          fidx = int'(m_addr[31:2]) % NSETS;
          m_valid[fidx] = 1'b1;
          m_tag[fidx]   = m_addr >> (IDX_W + 2);
          m_data[fidx]  = bus.iload;
          m_pend        = 1'b0;
        end
      end else if (bus.imemREN && !exp_hit) begin
        m_pend   = 1'b1;
        m_addr   = {bus.imemaddr[31:2], 2'b00};
        m_misses = m_misses + 32'd1;
      end
    end
  end

  // Sets all inputs for the next clock cycle, just after the rising edge.
  task automatic applyStimulus(input logic ren, input word_t addr, input logic wt,
                               input word_t ld, input lit_sel_t sel = L_NONE,
                               input word_t exp = 32'h0, input string name = "");
    @(posedge clk);
    #1;
    rst          = 1'b0;
    bus.imemREN  = ren;
    bus.imemaddr = addr;
    bus.iwait    = wt;
    bus.iload    = ld;
    lit_sel      = sel;
    lit_exp      = exp;
    lit_name     = name;
  endtask

  // One reset cycle; the fetch and memory inputs keep their values.
  task automatic applyReset();
    @(posedge clk);
    #1;
    rst     = 1'b1;
    lit_sel = L_NONE;
  endtask

  // Cold miss: detect, nwait busy cycles, then a completing read.
  task automatic doMiss(input word_t addr, input word_t data, input int nwait);
    applyStimulus(1'b1, addr, 1'b1, 32'h0, L_IHIT, 32'h0, "miss_detect_ihit");
    for (int i = 0; i < nwait; i++)
      applyStimulus(1'b1, addr, 1'b1, 32'h0, L_IADDR, addr, "miss_wait_iaddr");
    applyStimulus(1'b1, addr, 1'b0, data, L_IADDR, addr, "miss_complete_iaddr");
  endtask

  initial begin
    bus.imemREN  = 1'b0;
    bus.imemaddr = '0;
    bus.iwait    = 1'b1;
    bus.iload    = '0;

    // Reset values
    applyReset();
    applyStimulus(1'b0, 32'h40, 1'b1, 32'h0, L_IHIT,  32'h0, "reset_ihit");
    applyStimulus(1'b0, 32'h40, 1'b1, 32'h0, L_LOAD,  32'h0, "reset_imemload");
    applyStimulus(1'b0, 32'h40, 1'b1, 32'h0, L_IREN,  32'h0, "reset_iren");
    applyStimulus(1'b0, 32'h40, 1'b1, 32'h0, L_IADDR, 32'h0, "reset_iaddr");

    // Cold miss at 0x40: detect cycle, then iREN for 4 cycles
    applyStimulus(1'b1, 32'h40, 1'b1, 32'h0, L_IHIT, 32'h0, "cold_detect_ihit");
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, 32'h40, 1'b1, 32'h0, L_IADDR, 32'h40, "cold_wait_iaddr");
    applyStimulus(1'b1, 32'h40, 1'b0, 32'h2002_0005, L_IREN, 32'h1, "cold_complete_iren");
    applyStimulus(1'b1, 32'h40, 1'b1, 32'h0, L_LOAD, 32'h2002_0005, "cold_refetch_load");
    applyStimulus(1'b1, 32'h40, 1'b1, 32'h0, L_IREN, 32'h0, "repeat_hit_iren");

    // Conflict eviction on index 1
    doMiss(32'h04, 32'h1111_0004, 0);
    applyStimulus(1'b1, 32'h04, 1'b1, 32'h0, L_LOAD, 32'h1111_0004, "alias_a_hit");
    doMiss(32'h44, 32'h2222_0044, 1);
    applyStimulus(1'b1, 32'h44, 1'b1, 32'h0, L_LOAD, 32'h2222_0044, "alias_b_hit");
    applyStimulus(1'b1, 32'h04, 1'b1, 32'h0, L_IHIT, 32'h0, "alias_a_evicted");
    applyStimulus(1'b1, 32'h04, 1'b0, 32'h1111_0004, L_IADDR, 32'h04, "alias_refill_iaddr");
    applyStimulus(1'b1, 32'h04, 1'b1, 32'h0, L_LOAD, 32'h1111_0004, "alias_refill_hit");

    // Top index must not disturb index 0; byte offset ignored; REN low
    doMiss(32'h3C, 32'h3333_003C, 0);
    applyStimulus(1'b1, 32'h40, 1'b1, 32'h0, L_LOAD, 32'h2002_0005, "idx0_intact");
    applyStimulus(1'b1, 32'h3F, 1'b1, 32'h0, L_LOAD, 32'h3333_003C, "idx15_byte_offset");
    applyStimulus(1'b0, 32'h3C, 1'b1, 32'h0, L_IHIT, 32'h0, "ren_low_ihit");
    applyStimulus(1'b0, 32'h3C, 1'b1, 32'h0, L_LOAD, 32'h0, "ren_low_load");

    // Redirect during FETCH: fill of 0x80 must complete regardless
    applyStimulus(1'b1, 32'h80,  1'b1, 32'h0, L_IHIT, 32'h0, "redirect_detect");
    applyStimulus(1'b1, 32'h100, 1'b1, 32'h0, L_IADDR, 32'h80, "redirect_iaddr_a");
    applyStimulus(1'b0, 32'h100, 1'b1, 32'h0, L_IADDR, 32'h80, "redirect_iaddr_b");
    applyStimulus(1'b1, 32'h100, 1'b0, 32'hAAAA_0080, L_IREN, 32'h1, "redirect_complete");
    applyStimulus(1'b1, 32'h80,  1'b1, 32'h0, L_LOAD, 32'hAAAA_0080, "redirect_frame0");
    applyStimulus(1'b1, 32'h100, 1'b1, 32'h0, L_IHIT, 32'h0, "redirect_new_miss");
    applyStimulus(1'b1, 32'h100, 1'b0, 32'hBBBB_0100, L_IADDR, 32'h100, "redirect_new_iaddr");
    applyStimulus(1'b1, 32'h100, 1'b1, 32'h0, L_LOAD, 32'hBBBB_0100, "redirect_new_hit");

    // Reset in the middle of a fill
    applyStimulus(1'b1, 32'h200, 1'b1, 32'h0, L_IHIT, 32'h0, "rst_mid_detect");
    applyStimulus(1'b1, 32'h200, 1'b1, 32'hDEAD_0200, L_IREN, 32'h1, "rst_mid_fetching");
    applyReset();
    applyStimulus(1'b1, 32'h200, 1'b1, 32'h0, L_IREN, 32'h0, "rst_mid_iren_drop");
    applyStimulus(1'b1, 32'h200, 1'b0, 32'hCCCC_0200, L_IADDR, 32'h200, "rst_mid_refetch");
    applyStimulus(1'b1, 32'h200, 1'b1, 32'h0, L_LOAD, 32'hCCCC_0200, "rst_mid_hit");
    applyStimulus(1'b1, 32'h40,  1'b1, 32'h0, L_IHIT, 32'h0, "rst_cleared_frames");
    applyStimulus(1'b1, 32'h40,  1'b0, 32'h2002_0005, L_IREN, 32'h1, "rst_refill_complete");
    applyStimulus(1'b1, 32'h40,  1'b1, 32'h0, L_LOAD, 32'h2002_0005, "rst_refill_hit");

`ifdef ICACHE_STATS_EN
    // 3 misses + 5 hits after a fresh reset
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h0);
    applyReset();
    doMiss(32'h300, 32'h0000_0030, 0);
    doMiss(32'h304, 32'h0000_0034, 1);
    doMiss(32'h308, 32'h0000_0038, 0);
    for (int i = 0; i < 5; i++)
      applyStimulus(1'b1, 32'h300 + 32'(4 * (i % 3)), 1'b1, 32'h0);
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h0, L_HITS, 32'd5, "stats_hits");
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h0, L_MISSES, 32'd3, "stats_misses");
    // Preload the hit counter to all-ones; one hit must wrap it to zero
    #1;
    force dut.u_hit_counter.count_q = 32'hFFFF_FFFF;
    hit_bias = 32'hFFFF_FFFF - 32'd5;
    #1;
    release dut.u_hit_counter.count_q;
    applyStimulus(1'b1, 32'h300, 1'b1, 32'h0, L_IHIT, 32'h1, "stats_wrap_hit");
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h0, L_HITS, 32'h0, "stats_hit_wrap");
`endif

    applyStimulus(1'b0, 32'h0, 1'b1, 32'h0);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
